// File: rtl/csa_seq_sched_pkg.sv
// Shared types and constants for the carry-skip adder sequencer/scheduler.
package csa_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int NIB_W = 4;
  localparam int ID_W  = 1;

endpackage

// File: rtl/csa_seq_sched_if.sv
// Request, shared-adder and response signals of csa_seq_sched.
// The slave modport is the scheduler; master is the surrounding system.
interface csa_seq_sched_if #(
  parameter int NUM_NIB = 4
);

  localparam int W = csa_seq_pkg::NIB_W * NUM_NIB;

  logic [1:0]                      req_valid;
  logic [1:0]                      req_ready;
  logic [1:0][W-1:0]               req_a;
  logic [1:0][W-1:0]               req_b;
  logic [1:0]                      req_cin;

  logic [csa_seq_pkg::NIB_W-1:0]   add_a;
  logic [csa_seq_pkg::NIB_W-1:0]   add_b;
  logic                            add_cin;
  logic [csa_seq_pkg::NIB_W-1:0]   add_sum;
  logic                            add_cout;

  logic                            rsp_valid;
  logic                            rsp_ready;
  logic [csa_seq_pkg::ID_W-1:0]    rsp_id;
  logic [W-1:0]                    rsp_sum;
  logic                            rsp_cout;

  modport master (
    output req_valid, req_a, req_b, req_cin, add_sum, add_cout, rsp_ready,
    input  req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, add_sum, add_cout, rsp_ready,
    output req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

endinterface

// File: rtl/csa_seq_sched_rr_arb2.sv
// Two-way round-robin grant; the pointer moves past whoever was just accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output logic       gnt_id
);

  logic ptr;

  always_comb begin
    gnt_id = ptr;
    if (req == 2'b01)
      gnt_id = 1'b0;
    else if (req == 2'b10)
      gnt_id = 1'b1;
    grant = 2'b00;
    if (en)
      grant[gnt_id] = req[gnt_id];
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= 1'b0;
    else if (|grant)
      ptr <= ~gnt_id;
  end

endmodule

// File: rtl/csa_seq_sched.sv
// Sequences 16-bit adds as LSB-first nibble passes through one external 4-bit
// adder, serving two requesters round-robin.
//
//   state | meaning
//   IDLE  | waiting for a request; req_ready follows the arbiter grant
//   ADD   | one nibble pass per cycle, carry chained through add_cin
//   RESP  | result held on rsp_* until rsp_ready
module csa_seq_sched #(
  parameter int NUM_NIB = 4
) (
  input  logic             clk,
  input  logic             rst,
  csa_seq_sched_if.slave   bus
);

  import csa_seq_pkg::*;

  localparam int            W    = NIB_W * NUM_NIB;
  localparam int            CW   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_NIB - 1);

  state_t           state;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic [CW-1:0]    nib;
  logic [CW-1:0]    nib_nxt;
  logic [NIB_W-1:0] a_nxt;
  logic [NIB_W-1:0] b_nxt;
  logic [1:0]       grant;
  logic             gnt_id;
  logic             accept;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (state == IDLE),
    .req    (bus.req_valid),
    .grant  (grant),
    .gnt_id (gnt_id)
  );

  assign bus.req_ready = grant;
  assign accept        = |grant;
  assign nib_nxt       = nib + 1'b1;
  assign a_nxt         = op_a[NIB_W*int'(nib_nxt) +: NIB_W];
  assign b_nxt         = op_b[NIB_W*int'(nib_nxt) +: NIB_W];

  // add_cin doubles as the inter-pass carry register
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      nib           <= '0;
      op_a          <= '0;
      op_b          <= '0;
      bus.add_a     <= '0;
      bus.add_b     <= '0;
      bus.add_cin   <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_sum   <= '0;
      bus.rsp_cout  <= 1'b0;
      bus.rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a        <= bus.req_a[gnt_id];
            op_b        <= bus.req_b[gnt_id];
            bus.add_a   <= bus.req_a[gnt_id][NIB_W-1:0];
            bus.add_b   <= bus.req_b[gnt_id][NIB_W-1:0];
            bus.add_cin <= bus.req_cin[gnt_id];
            bus.rsp_id  <= gnt_id;
            nib         <= '0;
            state       <= ADD;
          end
        end
        ADD: begin
          bus.rsp_sum[NIB_W*int'(nib) +: NIB_W] <= bus.add_sum;
          nib <= nib_nxt;
          if (nib == LAST) begin
            bus.add_a     <= '0;
            bus.add_b     <= '0;
            bus.add_cin   <= 1'b0;
            bus.rsp_cout  <= bus.add_cout;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else begin
            bus.add_a   <= a_nxt;
            bus.add_b   <= b_nxt;
            bus.add_cin <= bus.add_cout;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_seq_sched.sv
// Scoreboard bench for csa_seq_sched: accepts push expected results, a
// negedge monitor checks adder passes, grants and responses.
`timescale 1ns/1ps
module tb_csa_seq_sched;

  localparam int NUM_NIB = 4;
  localparam int W       = 4 * NUM_NIB;

  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csa_seq_sched_if #(.NUM_NIB(NUM_NIB)) bus ();

  csa_seq_sched #(.NUM_NIB(NUM_NIB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // the external 4-bit adder
  assign {bus.add_cout, bus.add_sum} = 5'(bus.add_a) + 5'(bus.add_b) + 5'(bus.add_cin);

  int          tests = 0;
  int          fails = 0;
  req_t        exp_q[$];
  int          grant_log[$];
  req_t        op;
  req_t        rsp_exp;
  req_t        r;
  logic        exp_id;
  logic        model_ptr;
  bit          busy = 0;
  bit          after_hs = 0;
  int          lat = -1;
  int          rsp_count = 0;
  logic [16:0] last_rsp;
  logic        last_id;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] model_sum(input req_t q);
    return 17'(q.a) + 17'(q.b) + 17'(q.cin);
  endfunction

  // carry into nibble k from plain arithmetic on the low 4k bits
  function automatic logic carry_in(input req_t q, input int k);
    longint m, s;
    if (k == 0) return q.cin;
    m = (longint'(1) << (4 * k)) - 1;
    s = (longint'(q.a) & m) + (longint'(q.b) & m) + longint'(q.cin);
    return ((s >> (4 * k)) & 1) != 0;
  endfunction

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return '0;
      2:       return W'(16'h00FF);
      default: return W'($urandom);
    endcase
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      busy      = 0;
      after_hs  = 0;
      lat       = -1;
      model_ptr = 1'b0;
      exp_q.delete();
    end else begin
      chk("ready_onehot", 32'(bus.req_ready != 2'b11), 1);
      if (after_hs) begin
        chk("idle_after_rsp", 32'(bus.rsp_valid), 0);
        after_hs = 0;
      end
      if (busy) begin
        lat++;
        chk("ready_while_busy", 32'(bus.req_ready), 0);
        if (lat < NUM_NIB) begin
          chk("add_a", 32'(bus.add_a), 32'(4'(op.a >> (4 * lat))));
          chk("add_b", 32'(bus.add_b), 32'(4'(op.b >> (4 * lat))));
          chk("add_cin", 32'(bus.add_cin), 32'(carry_in(op, lat)));
          chk("valid_early", 32'(bus.rsp_valid), 0);
        end else begin
          chk("add_idle_resp", {bus.add_a, bus.add_b, bus.add_cin}, 0);
          if (lat == NUM_NIB) begin
            chk("rsp_latency", 32'(bus.rsp_valid), 1);
            if (exp_q.size() == 0) begin
              chk("scoreboard_empty", 1, 0);
              rsp_exp = op;
            end else begin
              rsp_exp = exp_q.pop_front();
            end
          end else begin
            chk("rsp_valid_held", 32'(bus.rsp_valid), 1);
          end
          if (bus.rsp_valid) begin
            chk("rsp_id", 32'(bus.rsp_id), 32'(rsp_exp.id));
            chk("rsp_sum_cout", {bus.rsp_cout, bus.rsp_sum}, 32'(model_sum(rsp_exp)));
            if (bus.rsp_ready) begin
              busy     = 0;
              after_hs = 1;
              rsp_count++;
              last_rsp = {bus.rsp_cout, bus.rsp_sum};
              last_id  = bus.rsp_id;
            end
          end
        end
      end else begin
        chk("add_idle", {bus.add_a, bus.add_b, bus.add_cin}, 0);
        chk("unexpected_rsp", 32'(bus.rsp_valid), 0);
        if (bus.req_valid == 2'b00) begin
          chk("ready_no_req", 32'(bus.req_ready), 0);
        end else begin
          exp_id = (bus.req_valid == 2'b11) ? model_ptr : bus.req_valid[1];
          chk("grant", 32'(bus.req_ready), 32'(2'b01 << exp_id));
          if (bus.req_ready != 2'b00) begin
            r.id  = exp_id;
            r.a   = bus.req_a[exp_id];
            r.b   = bus.req_b[exp_id];
            r.cin = bus.req_cin[exp_id];
            exp_q.push_back(r);
            grant_log.push_back(int'(exp_id));
            op        = r;
            model_ptr = ~exp_id;
            busy      = 1;
            lat       = -1;
          end
        end
      end
    end
  end

  task automatic send(input int g, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    bus.req_a[g]     = a;
    bus.req_b[g]     = b;
    bus.req_cin[g]   = c;
    bus.req_valid[g] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.req_ready[g]) begin
        @(posedge clk);
        #1;
        bus.req_valid[g] = 1'b0;
        bus.req_a[g]     = W'($urandom);
        bus.req_b[g]     = W'($urandom);
        return;
      end
    end
    chk("send_timeout", 0, 1);
    bus.req_valid[g] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #2;
      if (!busy && !bus.rsp_valid) return;
    end
    chk("idle_timeout", 0, 1);
  endtask

  initial begin
    logic [1:0] acc;
    int         n0;

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_cout, bus.rsp_id, bus.rsp_sum}, 0);
    chk("rst_add", {bus.add_a, bus.add_b, bus.add_cin}, 0);
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.rsp_ready = 1'b1;

    send(0, 16'h1234, 16'h4321, 1'b0);
    wait_idle();
    chk("dir_5555", 32'(last_rsp), 32'h0_5555);
    chk("dir_5555_id", 32'(last_id), 0);
    send(1, 16'hFFFF, 16'h0001, 1'b0);
    wait_idle();
    chk("dir_carry_chain", 32'(last_rsp), 32'h1_0000);
    chk("dir_carry_chain_id", 32'(last_id), 1);
    send(0, 16'h00FF, 16'h0000, 1'b1);
    wait_idle();
    chk("dir_cin", 32'(last_rsp), 32'h0_0100);

    // both requesters valid continuously after a reset
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    grant_log.delete();
    bus.req_valid = 2'b11;
    for (int i = 0; i < 200 && grant_log.size() < 6; i++) begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++)
        if (acc[g]) begin
          bus.req_a[g]   = rand_op();
          bus.req_b[g]   = rand_op();
          bus.req_cin[g] = 1'($urandom);
        end
    end
    bus.req_valid = 2'b00;
    wait_idle();
    if (grant_log.size() >= 6) begin
      for (int i = 0; i < 6; i++) chk("alt_grant", 32'(grant_log[i]), 32'(i % 2));
    end else begin
      chk("alt_grant_count", 32'(grant_log.size()), 6);
    end

    // consumer stalls for 10 cycles while requester 1 waits
    bus.rsp_ready = 1'b0;
    send(0, 16'hBEEF, 16'h1357, 1'b1);
    bus.req_a[1]     = 16'h0F0F;
    bus.req_b[1]     = 16'hF0F1;
    bus.req_cin[1]   = 1'b0;
    bus.req_valid[1] = 1'b1;
    for (int i = 0; i < 20 && !bus.rsp_valid; i++) begin
      @(posedge clk);
      #2;
    end
    repeat (10) @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    send(1, 16'h0F0F, 16'hF0F1, 1'b0);
    wait_idle();
    chk("stall_then_req1", 32'(last_rsp), 32'h1_0000);

    // reset during the second adder pass
    send(0, 16'hABCD, 16'h1111, 1'b0);
    n0 = rsp_count;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("abort_add", {bus.add_a, bus.add_b, bus.add_cin}, 0);
    chk("abort_ready", 32'(bus.req_ready), 0);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_rsp", 32'(rsp_count), 32'(n0));
    send(1, 16'h8000, 16'h8000, 1'b1);
    wait_idle();
    chk("after_abort", 32'(last_rsp), 32'h1_0001);

    // randomized traffic with random back-pressure
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      for (int g = 0; g < 2; g++)
        if (acc[g] || !bus.req_valid[g]) begin
          bus.req_valid[g] = ($urandom_range(0, 2) != 0);
          bus.req_a[g]     = rand_op();
          bus.req_b[g]     = rand_op();
          bus.req_cin[g]   = 1'($urandom);
        end
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    wait_idle();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/csa_seq_sched.md
# csa_seq_sched

Sequencer and two-port scheduler for the team's 4-bit carry-skip adder. It accepts 16-bit add requests from two requesters and grants them round-robin. Each granted operation runs as four nibble passes, least significant first, through one shared external 4-bit adder instance, with the carry chained between passes. The 16-bit sum and carry-out are returned on a valid/ready response channel tagged with the requester ID.

## Interface
- NUM_NIB, default 4: nibbles per operand; operand width is 4*NUM_NIB.
- clk  in  1  the only clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept; at most one bit set.
- req_a  in  2x16  operand A per requester.
- req_b  in  2x16  operand B per requester.
- req_cin  in  2  carry-in per requester.
- add_a  out  4  nibble of A driven to the shared adder.
- add_b  out  4  nibble of B driven to the shared adder.
- add_cin  out  1  carry into the shared adder.
- add_sum  in  4  adder sum; combinational from add_a, add_b and add_cin.
- add_cout  in  1  adder carry-out.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_id  out  1  requester the result belongs to.
- rsp_sum  out  16  result sum.
- rsp_cout  out  1  final carry-out.

## Operation
- FSM states are IDLE, ADD and RESP.
- **IDLE:**
  - req_ready[g] = req_valid[g] for the granted requester g; the other bit is 0.
  - On the accept edge, latch a, b, cin and id; set nib = 0; go to ADD.
- **Arbitration:** round-robin pointer ptr, reset to 0.
  - Both requests valid: grant ptr.
  - One request valid: grant that one.
  - On each accept, ptr <= ~id.
- **ADD:**
  - Drive add_a = A[4*nib+3 : 4*nib] and add_b likewise.
  - Drive add_cin = cin when nib = 0, otherwise the carry registered on the previous pass.
  - Each edge: sum nibble nib <= add_sum; carry <= add_cout; nib <= nib + 1.
  - After nib = NUM_NIB-1, go to RESP.
- **RESP:**
  - rsp_valid = 1; rsp_sum, rsp_cout and rsp_id stay stable.
  - On rsp_valid && rsp_ready, go to IDLE.
- Outside ADD, add_a, add_b and add_cin are driven to 0.
- Arithmetic: {rsp_cout, rsp_sum} = A + B + cin, modulo 2^17. No overflow flag.
- Request operands may change after the accept edge without affecting the result.
- **Reset values:**
  - state IDLE, ptr 0, req_ready 0.
  - rsp_valid 0, rsp_sum 0, rsp_cout 0, rsp_id 0.
  - add_a, add_b, add_cin all 0.
- Reset mid-ADD or mid-RESP aborts the operation; the result is discarded and never presented.

## Timing
- Accept on edge E0. ADD passes occupy the cycles after E0..E3.
- rsp_valid rises after edge E4: 4 cycles latency for NUM_NIB = 4.
- RESP holds for at least one cycle. If rsp_ready is high on the first RESP cycle, return to IDLE at E5.
- The next accept is at E6 at the earliest, so the minimum occupancy is 6 cycles per operation.
- req_ready is combinational from state, ptr and req_valid. There is no combinational path from req_* to rsp_*.
- A requester keeping req_valid high after its accept is treated as a new request and competes round-robin normally.
- rsp_ready asserted outside RESP is ignored.

## Structure
- Package csa_seq_pkg holds:
  - the state enum (IDLE, ADD, RESP);
  - localparam NIB_W = 4;
  - the ID width.
- Sub-module rr_arb2 is a 2-way round-robin grant with pointer update on accept.
- Everything else lives in csa_seq_sched: FSM, nibble counter, operand and result registers.
- The adder itself stays outside; the top level wires add_* to the carry-skip adder instance.

## Test plan
- Requester 0 sends 0x1234 + 0x4321, cin 0, with rsp_ready high → rsp_valid 4 cycles after accept; rsp_sum 0x5555, rsp_cout 0, rsp_id 0.
- Requester 1 sends 0xFFFF + 0x0001, cin 0 → rsp_sum 0x0000, rsp_cout 1; the carry propagates through all 4 passes.
- Requester 0 sends 0x00FF + 0x0000, cin 1 → rsp_sum 0x0100, rsp_cout 0.
- Both requesters valid continuously after reset → grants alternate 0, 1, 0, 1; req_ready is never set on both bits.
- Hold rsp_ready low for 10 cycles in RESP → rsp_valid, rsp_sum and rsp_id stay stable and req_ready stays 0; release rsp_ready → IDLE on the next edge.
- Assert rst for one cycle during the 2nd ADD pass → next cycle state IDLE, rsp_valid 0, add_* 0; no response emitted; a fresh request then completes correctly.
